// File: rtl/gate_sweep_n.sv
// N-input gate with a registered live output and a truth-table sweeper.
// A sweep walks every input vector once, building a signature (tt) and a count of 1 results (ones).
module gate_sweep_n #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [N-1:0]        x,
  output logic                y,
  output logic                busy,
  output logic                done,
  output logic                sweep_valid,
  output logic [N-1:0]        sweep_x,
  output logic                sweep_y,
  output logic [(1<<N)-1:0]   tt,
  output logic [N:0]          ones
);

  localparam int         ROWS = 1 << N;
  localparam logic [N:0] LAST = (N+1)'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      smode_reg, smode_next;
  logic [N:0]      cnt_reg, cnt_next;
  logic            y_reg;
  logic            sweep_y_reg, sweep_y_next;
  logic [ROWS-1:0] tt_reg, tt_next, tt_base;
  logic [N:0]      ones_reg, ones_next, ones_base;

  logic            row_we;
  logic            tt_clear;
  logic [2:0]      row_mode;
  logic [N-1:0]    row_idx;
  logic            row_bit;

  function automatic logic gate_f(input logic [2:0] m, input logic [N-1:0] v);
    logic r;
    case (m)
      3'd0:    r = |v;
      3'd1:    r = ~|v;
      3'd2:    r = &v;
      3'd3:    r = ~&v;
      3'd4:    r = ^v;
      3'd5:    r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_next = state_reg;
    smode_next = smode_reg;
    cnt_next   = cnt_reg;
    row_we     = 1'b0;
    tt_clear   = 1'b0;
    row_mode   = smode_reg;
    case (state_reg)
      IDLE: begin
        // The accepting edge already presents row 0, so use the incoming mode for it.
        if (start) begin
          state_next = SWEEP;
          smode_next = mode;
          cnt_next   = '0;
          row_mode   = mode;
          row_we     = 1'b1;
          tt_clear   = 1'b1;
        end
      end
      SWEEP: begin
        if (cnt_reg == LAST) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          row_we   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign row_idx      = cnt_next[N-1:0];
  assign row_bit      = gate_f(row_mode, row_idx);
  assign sweep_y_next = row_we & row_bit;

  assign tt_base   = tt_clear ? '0 : tt_reg;
  assign ones_base = tt_clear ? '0 : ones_reg;
  assign ones_next = ones_base + {{N{1'b0}}, sweep_y_next};

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_tt
      assign tt_next[gi] = (row_we && (row_idx == N'(gi))) ? row_bit : tt_base[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      smode_reg   <= '0;
      cnt_reg     <= '0;
      y_reg       <= 1'b0;
      sweep_y_reg <= 1'b0;
      tt_reg      <= '0;
      ones_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      smode_reg   <= smode_next;
      cnt_reg     <= cnt_next;
      y_reg       <= gate_f(mode, x);
      sweep_y_reg <= sweep_y_next;
      tt_reg      <= tt_next;
      ones_reg    <= ones_next;
    end
  end

  assign y           = y_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign sweep_valid = (state_reg == SWEEP);
  assign sweep_x     = cnt_reg[N-1:0];
  assign sweep_y     = sweep_y_reg;
  assign tt          = tt_reg;
  assign ones        = ones_reg;

endmodule

// File: doc/gate_sweep_n.md
GATE_SWEEP_N -- requirements
Module: gate_sweep_n

Interface
REQ-001 SHALL have parameter N, default 3, meaning number of gate inputs (legal 2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a truth-table sweep; sampled only in IDLE.
REQ-005 SHALL have port mode  input  3  gate function: 0 OR, 1 NOR, 2 AND, 3 NAND, 4 XOR, 5 XNOR, 6/7 reserved (function = constant 0).
REQ-006 SHALL have port x  input  N  live gate inputs.
REQ-007 SHALL have port y  output  1  registered gate result for live inputs.
REQ-008 SHALL have port busy  output  1  high in SWEEP and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse, sweep complete.
REQ-010 SHALL have port sweep_valid  output  1  sweep_x/sweep_y hold a valid truth-table row.
REQ-011 SHALL have port sweep_x  output  N  current sweep input vector.
REQ-012 SHALL have port sweep_y  output  1  gate result for sweep_x.
REQ-013 SHALL have port tt  output  2**N  truth-table signature, bit i = f(i).
REQ-014 SHALL have port ones  output  N+1  count of 1 results in the last/current sweep.

Function
REQ-015 Live path: y SHALL equal f(mode, x) sampled at the previous rising edge (latency 1), independent of sweep state.
REQ-016 FSM SHALL have states IDLE, SWEEP, DONE; IDLE after reset.
REQ-017 IDLE with start=1 at edge k: mode latched into smode, tt and ones cleared, cnt=0, state SWEEP; after edge k busy=1, sweep_valid=1, sweep_x=0.
REQ-018 In SWEEP each edge SHALL advance cnt by 1; after edge k+j (0<=j<2**N) sweep_x=j, sweep_y=f(smode, j).
REQ-019 tt[j] SHALL be written with f(smode, j) at the same edge that presents row j, so tt[sweep_x]==sweep_y while sweep_valid=1.
REQ-020 ones SHALL increment at the same edge whenever the presented row yields 1; width N+1 so 2**N never wraps.
REQ-021 After the last row (sweep_x=2**N-1) the next edge SHALL enter DONE: done=1, sweep_valid=0, busy=1, tt and ones final.
REQ-022 DONE SHALL return to IDLE at the next edge: done=0, busy=0; total busy time 2**N+1 cycles.
REQ-023 start SHALL be ignored in SWEEP and DONE; start held high continuously SHALL re-trigger only from IDLE.
REQ-024 Changes on mode during SWEEP SHALL affect y only, never the sweep (smode used).
REQ-025 tt and ones SHALL hold their values in IDLE until the next accepted start.
REQ-026 sweep_x SHALL hold its last value when sweep_valid=0; sweep_y SHALL be 0 when sweep_valid=0.
REQ-027 cnt SHALL be N+1 bits wide internally; terminal detection on cnt==2**N-1, no wrap into row 0.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE and y=0, busy=0, done=0, sweep_valid=0, sweep_x=0, sweep_y=0, tt=0, ones=0.
REQ-029 rst SHALL take priority over start in the same cycle and SHALL abort a sweep at any row, discarding partial tt/ones.

Verification (N=3)
REQ-030 mode=0, start pulse at edge k -> rows 0..7 after edges k..k+7, done=1 after edge k+8, tt=8'hFE, ones=7, busy low after edge k+9.
REQ-031 Sweeps with mode=2, 4, 3 -> tt=8'h80/ones=1, tt=8'h96/ones=4, tt=8'h7F/ones=7 respectively.
REQ-032 mode=1, x=3'b000 -> y=1 one edge later; x=3'b010 -> y=0 one edge later; mode=6 -> y=0.
REQ-033 rst asserted while sweep_x=4 -> after that edge all outputs zero, IDLE; new start yields complete correct tt.
REQ-034 start held high throughout and mode toggled mid-sweep -> single sweep uses latched mode, one done pulse, next sweep begins from IDLE after DONE.
